// File: rtl/ram_responder_if.sv
// ram_responder_if: memory-controller, host TX/RX and status signals.
// master drives requests and host data; slave is the responder.
interface ram_responder_if;
    logic        ramRW_in;
    logic [31:0] ramAddr_in;
    logic [7:0]  ramData_in;
    logic [7:0]  ramData_out;
    logic [7:0]  txData_out;
    logic        txValid_out;
    logic        txReady_in;
    logic [7:0]  rxData_in;
    logic        rxValid_in;
    logic        rxReady_out;
    logic        halt_out;
    logic        txOvf_out;

    modport master (
        output ramRW_in, ramAddr_in, ramData_in,
        output txReady_in, rxData_in, rxValid_in,
        input  ramData_out, txData_out, txValid_out,
        input  rxReady_out, halt_out, txOvf_out
    );

    modport slave (
        input  ramRW_in, ramAddr_in, ramData_in,
        input  txReady_in, rxData_in, rxValid_in,
        output ramData_out, txData_out, txValid_out,
        output rxReady_out, halt_out, txOvf_out
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: byte RAM with a registered read port.
// Define RAM_IO_EN to map TX/RX FIFOs, halt and overflow at 0x30000/0x30004.
module ram_responder #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input logic            clk_in,
    input logic            rst_in,
    ram_responder_if.slave bus
);

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              run;
    logic              mem_wr;
    logic [7:0]        rd_data;

    assign idx = bus.ramAddr_in[ADDR_W-1:0];

    // run drops with reset, so an access caught by reset never writes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && run) mem[idx] <= bus.ramData_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)             bus.ramData_out <= 8'h00;
        else if (!bus.ramRW_in) bus.ramData_out <= rd_data;
    end

`ifdef RAM_IO_EN
    localparam int            PW   = $clog2(FIFO_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [7:0]    tx_buf [FIFO_DEPTH];
    logic [7:0]    rx_buf [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          is_io, sel_dat, sel_sta;
    logic          tx_full, rx_full, rx_ne;
    logic          tx_push, tx_pop, tx_drop;
    logic          rx_push, rx_pop, halt_set;
    logic          halt, ovf;

    assign is_io   = bus.ramAddr_in[17:16] == 2'b11;
    assign sel_dat = bus.ramAddr_in == 32'h0003_0000;
    assign sel_sta = bus.ramAddr_in == 32'h0003_0004;
    assign tx_full = tx_cnt == FULL;
    assign rx_full = rx_cnt == FULL;
    assign rx_ne   = rx_cnt != '0;

    always_comb begin
        mem_wr   = bus.ramRW_in && !is_io;
        tx_pop   = (tx_cnt != '0) && bus.txReady_in;
        rx_push  = bus.rxValid_in && run && !rx_full;
        tx_push  = 1'b0;
        tx_drop  = 1'b0;
        rx_pop   = 1'b0;
        halt_set = 1'b0;
        rd_data  = mem[idx];
        if (is_io) begin
            rd_data = 8'h00;
            if (bus.ramRW_in) begin
                // a same-cycle drain frees the slot for this push
                tx_push  = sel_dat && (!tx_full || tx_pop);
                tx_drop  = sel_dat && tx_full && !tx_pop;
                halt_set = sel_sta;
            end else if (sel_dat) begin
                rx_pop = rx_ne;
                if (rx_ne) rd_data = rx_buf[rx_rp];
            end else if (sel_sta) begin
                rd_data = {6'b0, rx_ne, tx_full};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            halt   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (halt_set) halt <= 1'b1;
            if (tx_drop)  ovf  <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_buf[tx_wp] <= bus.ramData_in;
        if (rx_push) rx_buf[rx_wp] <= bus.rxData_in;
    end

    assign bus.txValid_out = tx_cnt != '0;
    assign bus.txData_out  = tx_buf[tx_rp];
    assign bus.rxReady_out = run && !rx_full;
    assign bus.halt_out    = halt;
    assign bus.txOvf_out   = ovf;
`else
    logic unused_io;

    assign unused_io = ^{bus.ramAddr_in[31:ADDR_W], bus.txReady_in,
                         bus.rxData_in, bus.rxValid_in,
                         FIFO_DEPTH != 0};

    assign mem_wr          = bus.ramRW_in;
    assign rd_data         = mem[idx];
    assign bus.txValid_out = 1'b0;
    assign bus.txData_out  = 8'h00;
    assign bus.rxReady_out = 1'b0;
    assign bus.halt_out    = 1'b0;
    assign bus.txOvf_out   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of array access, reset and,
// when RAM_IO_EN is defined, the FIFO/halt IO window.
module tb_ram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_responder_if bus ();

    ram_responder dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.ramRW_in   = 1'b1;
        bus.ramAddr_in = a;
        bus.ramData_in = d;
        cyc();
        bus.ramRW_in   = 1'b0;
        bus.ramAddr_in = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.ramRW_in   = 1'b0;
        bus.ramAddr_in = a;
        cyc();
        bus.ramAddr_in = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        bus.ramRW_in   = 1'b0;
        bus.ramAddr_in = 32'h0;
        bus.ramData_in = 8'h00;
        bus.txReady_in = 1'b0;
        bus.rxData_in  = 8'h00;
        bus.rxValid_in = 1'b0;

        @(negedge clk);
        chk("rst_data", bus.ramData_out, 8'h00);
        chk("rst_txv", bus.txValid_out, 1'b0);
        chk("rst_rxr", bus.rxReady_out, 1'b0);
        chk("rst_halt", bus.halt_out, 1'b0);
        chk("rst_ovf", bus.txOvf_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
`ifdef RAM_IO_EN
        chk("rxr_post_rst", bus.rxReady_out, 1'b1);
`else
        chk("rxr_post_rst", bus.rxReady_out, 1'b0);
`endif

        wr(32'h10, 8'hA5);
        rd(32'h10);
        chk("rd_a5", bus.ramData_out, 8'hA5);
        wr(32'h1FFFF, 8'h3C);
        rd(32'h1FFFF);
        chk("rd_top", bus.ramData_out, 8'h3C);
        wr(32'h20010, 8'h11);
        rd(32'h10);
        chk("rd_alias", bus.ramData_out, 8'h11);
        rd(32'h1FFFF);
        wr(32'h40, 8'h99);
        chk("wr_holds", bus.ramData_out, 8'h3C);
        rd(32'h40);
        chk("rd_99", bus.ramData_out, 8'h99);

        wr(32'h50, 8'h12);
        bus.ramRW_in   = 1'b1;
        bus.ramAddr_in = 32'h50;
        bus.ramData_in = 8'hEE;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_data", bus.ramData_out, 8'h00);
        chk("async_rst_rxr", bus.rxReady_out, 1'b0);
        @(negedge clk);
        bus.ramRW_in   = 1'b0;
        bus.ramAddr_in = 32'h0;
        rst            = 1'b0;
        cyc();
        rd(32'h50);
        chk("abandoned_wr", bus.ramData_out, 8'h12);

`ifdef RAM_IO_EN
        bus.rxValid_in = 1'b1;
        bus.rxData_in  = 8'h41;
        cyc();
        bus.rxData_in  = 8'h42;
        cyc();
        bus.rxValid_in = 1'b0;
        rd(32'h30004);
        chk("rx_status", bus.ramData_out, 8'h02);
        rd(32'h30000);
        chk("rx_41", bus.ramData_out, 8'h41);
        rd(32'h30000);
        chk("rx_42", bus.ramData_out, 8'h42);
        rd(32'h30000);
        chk("rx_empty", bus.ramData_out, 8'h00);

        bus.rxValid_in = 1'b1;
        bus.rxData_in  = 8'h55;
        rd(32'h30000);
        bus.rxValid_in = 1'b0;
        chk("rx_push_pop_empty", bus.ramData_out, 8'h00);
        rd(32'h30000);
        chk("rx_retained", bus.ramData_out, 8'h55);

        rd(32'h10);
        rd(32'h30008);
        chk("io_other_rd", bus.ramData_out, 8'h00);
        wr(32'h30008, 8'hAB);
        rd(32'h30004);
        chk("io_other_wr", bus.ramData_out, 8'h00);
        chk("io_other_halt", bus.halt_out, 1'b0);

        bus.rxValid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rxData_in = 8'(8'h60 + i);
            cyc();
        end
        chk("rx_full_rdy", bus.rxReady_out, 1'b0);
        bus.rxData_in = 8'hFF;
        cyc();
        bus.rxValid_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd(32'h30000);
            chk("rx_drain", bus.ramData_out, 8'(8'h60 + i));
        end
        rd(32'h30000);
        chk("rx_drop_full", bus.ramData_out, 8'h00);

        bus.txReady_in = 1'b0;
        for (int i = 0; i < 16; i++) wr(32'h30000, 8'(i));
        chk("tx_no_ovf", bus.txOvf_out, 1'b0);
        rd(32'h30004);
        chk("tx_status_full", bus.ramData_out, 8'h01);
        wr(32'h30000, 8'h10);
        chk("tx_ovf", bus.txOvf_out, 1'b1);
        bus.txReady_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_valid", bus.txValid_out, 1'b1);
            chk("tx_data", bus.txData_out, 8'(i));
            cyc();
        end
        chk("tx_drained", bus.txValid_out, 1'b0);
        bus.txReady_in = 1'b0;
        chk("tx_ovf_sticky", bus.txOvf_out, 1'b1);

        wr(32'h30004, 8'h00);
        chk("halt_set", bus.halt_out, 1'b1);
        repeat (100) cyc();
        chk("halt_sticky", bus.halt_out, 1'b1);
        do_reset();
        chk("halt_cleared", bus.halt_out, 1'b0);
        chk("ovf_cleared", bus.txOvf_out, 1'b0);

        for (int i = 0; i < 16; i++) wr(32'h30000, 8'(8'h20 + i));
        bus.txReady_in = 1'b1;
        wr(32'h30000, 8'h80);
        chk("tx_full_push_pop", bus.txOvf_out, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("tx_pp_data", bus.txData_out,
                (i < 15) ? 8'(8'h21 + i) : 8'h80);
            cyc();
        end
        chk("tx_pp_drained", bus.txValid_out, 1'b0);
        bus.txReady_in = 1'b0;

        wr(32'h30000, 8'hC1);
        wr(32'h30000, 8'hC2);
        wr(32'h30000, 8'hC3);
        chk("tx3_valid", bus.txValid_out, 1'b1);
        chk("tx3_head", bus.txData_out, 8'hC1);
        rst = 1'b1;
        #1;
        chk("rst_txv_async", bus.txValid_out, 1'b0);
        chk("rst_rxr_async", bus.rxReady_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("tx_after_rst", bus.txValid_out, 1'b0);
`else
        wr(32'h30000, 8'h5A);
        rd(32'h30000);
        chk("noio_rd", bus.ramData_out, 8'h5A);
        chk("noio_txv", bus.txValid_out, 1'b0);
        wr(32'h30004, 8'h01);
        chk("noio_halt", bus.halt_out, 1'b0);
        chk("noio_ovf", bus.txOvf_out, 1'b0);
        rd(32'h30004);
        chk("noio_rd4", bus.ramData_out, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
